// File: rtl/doodle_motion.sv
// Purpose: player physics for Doodle Jump: frame tick, horizontal wrap, gravity/bounce, top clamp to scroll.
// Latency: all outputs are registered and change one clk after a frame_tick edge (frame_tick itself one clk after the divider wraps).
// Backpressure: none; inputs are sampled on update edges only and nothing upstream is stalled.
module doodle_motion #(
  parameter int SCR_W     = 400,
  parameter int SCR_H     = 700,
  parameter int X_W       = 10,
  parameter int Y_W       = 10,
  parameter int V_W       = 8,
  parameter int TICK_DIV  = 1,
  parameter int GRAVITY   = 1,
  parameter int JUMP_V    = 16,
  parameter int MAX_FALL  = 16,
  parameter int MOVE_STEP = 4,
  parameter int TOP_LIMIT = 200,
  parameter int START_X   = 200,
  parameter int START_Y   = 600
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  left,
  input  logic                  right,
  input  logic                  on_platform,
  output logic                  frame_tick,
  output logic [X_W-1:0]        pos_x,
  output logic [Y_W-1:0]        pos_y,
  output logic signed [V_W-1:0] vel_y,
  output logic                  jump,
  output logic [Y_W-1:0]        scroll_amt,
  output logic                  game_over
);

  typedef enum logic [1:0] {IDLE, PLAY, DEAD} state_t;

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int NY_W  = Y_W + 2;

  localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [X_W:0]           STEP_X   = (X_W+1)'(MOVE_STEP);
  localparam logic [X_W:0]           SCR_WX   = (X_W+1)'(SCR_W);
  localparam logic [X_W:0]           WRAP_L   = (X_W+1)'(SCR_W - MOVE_STEP);
  localparam logic signed [V_W:0]    GRAV_V   = (V_W+1)'(GRAVITY);
  localparam logic signed [V_W:0]    NEG_MAX  = (V_W+1)'(-MAX_FALL);
  localparam logic signed [V_W-1:0]  V_ZERO   = '0;
  localparam logic signed [V_W-1:0]  JUMP_VV  = V_W'(JUMP_V);
  localparam logic signed [NY_W-1:0] TOP_S    = NY_W'(TOP_LIMIT);
  localparam logic signed [NY_W-1:0] BOT_S    = NY_W'(SCR_H);
  localparam logic [Y_W-1:0]         TOP_Y    = Y_W'(TOP_LIMIT);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        tick_cnt;
  logic [X_W-1:0]          x_d;
  logic [Y_W-1:0]          y_d;
  logic signed [V_W-1:0]   v_d;
  logic                    jump_d;
  logic [Y_W-1:0]          scroll_d;

  // Arithmetic shared by the next-state logic; widened so wrap and
  // clamp comparisons never overflow.
  logic [X_W:0]            x_ext, x_plus;
  logic signed [NY_W-1:0]  ny;
  logic signed [V_W:0]     nv_raw;
  logic signed [V_W-1:0]   nv;

  assign x_ext     = {1'b0, pos_x};
  assign x_plus    = x_ext + STEP_X;
  assign ny        = $signed({2'b00, pos_y}) - $signed({{(NY_W-V_W){vel_y[V_W-1]}}, vel_y});
  assign nv_raw    = $signed({vel_y[V_W-1], vel_y}) - GRAV_V;
  assign nv        = (nv_raw < NEG_MAX) ? V_W'(NEG_MAX) : V_W'(nv_raw);
  assign game_over = (state_q == DEAD);

  // Frame divider: frame_tick is high for the cycle after the counter's last value.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt   <= '0;
      frame_tick <= 1'b0;
    end else if (tick_cnt == CNT_LAST) begin
      tick_cnt   <= '0;
      frame_tick <= 1'b1;
    end else begin
      tick_cnt   <= tick_cnt + 1'b1;
      frame_tick <= 1'b0;
    end
  end

  // Next-state and physics: only an edge with frame_tick high moves anything.
  always_comb begin
    state_d  = state_q;
    x_d      = pos_x;
    y_d      = pos_y;
    v_d      = vel_y;
    jump_d   = 1'b0;
    scroll_d = scroll_amt;
    if (frame_tick) begin
      case (state_q)
        IDLE: begin
          if (start) state_d = PLAY;
        end
        PLAY: begin
          if (left && !right)
            x_d = (x_ext < STEP_X) ? X_W'(x_ext + WRAP_L) : X_W'(x_ext - STEP_X);
          else if (right && !left)
            x_d = (x_plus >= SCR_WX) ? X_W'(x_plus - SCR_WX) : X_W'(x_plus);

          // Landing only counts while not rising; rising through a platform is ignored.
          if (on_platform && (vel_y <= V_ZERO)) begin
            v_d      = JUMP_VV;
            jump_d   = 1'b1;
            scroll_d = '0;
          end else if (ny < TOP_S) begin
            y_d      = TOP_Y;
            v_d      = nv;
            scroll_d = Y_W'(TOP_S - ny);
          end else if (ny >= BOT_S) begin
            // Fell off the bottom: keep the last on-screen position and velocity.
            state_d  = DEAD;
            scroll_d = '0;
          end else begin
            y_d      = Y_W'(ny);
            v_d      = nv;
            scroll_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pos_x      <= X_W'(START_X);
      pos_y      <= Y_W'(START_Y);
      vel_y      <= '0;
      jump       <= 1'b0;
      scroll_amt <= '0;
    end else begin
      state_q    <= state_d;
      pos_x      <= x_d;
      pos_y      <= y_d;
      vel_y      <= v_d;
      jump       <= jump_d;
      scroll_amt <= scroll_d;
    end
  end

endmodule

// File: tb/tb_doodle_motion.sv
// Bench for doodle_motion: directed trajectories plus random play, checked against a tick-level model.
// Two instances: TICK_DIV=1 with START_X=198 (main), TICK_DIV=4 idle instance (divider check).
module tb_doodle_motion;

  localparam int W = 400, H = 700, STEP = 4, TOP = 200, JV = 16, MF = 16;
  localparam int SX = 198, SY = 600;

  logic clk = 1'b0;
  logic reset = 1'b0, start = 1'b0, left = 1'b0, right = 1'b0, on_platform = 1'b0;
  logic d_start = 1'b0, d_left = 1'b0, d_right = 1'b1;

  logic              ft, jmp, go;
  logic [9:0]        px, py, scr;
  logic signed [7:0] vy;
  logic              d_ft, d_jmp, d_go;
  logic [9:0]        d_px, d_py, d_scr;
  logic signed [7:0] d_vy;

  doodle_motion #(.TICK_DIV(1), .START_X(SX)) u_dut (
    .clk(clk), .reset(reset), .start(start), .left(left), .right(right),
    .on_platform(on_platform), .frame_tick(ft), .pos_x(px), .pos_y(py),
    .vel_y(vy), .jump(jmp), .scroll_amt(scr), .game_over(go));

  doodle_motion #(.TICK_DIV(4)) u_div (
    .clk(clk), .reset(reset), .start(d_start), .left(d_left), .right(d_right),
    .on_platform(on_platform), .frame_tick(d_ft), .pos_x(d_px), .pos_y(d_py),
    .vel_y(d_vy), .jump(d_jmp), .scroll_amt(d_scr), .game_over(d_go));

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  bit chk_en = 1'b0;

  // Model state: 0 idle, 1 play, 2 dead; m_n counts edges since reset.
  int m_st, m_x, m_y, m_v, m_jump, m_scroll, m_n;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int tick_exp(input int n, input int td);
    return (n > 0 && (n % td) == 0) ? 1 : 0;
  endfunction

  // Advance the model across one clock edge using the inputs present at that edge.
  task automatic model_edge();
    int ny, nv;
    bit upd;
    upd = (tick_exp(m_n, 1) == 1);
    if (reset) begin
      m_st = 0; m_x = SX; m_y = SY; m_v = 0; m_jump = 0; m_scroll = 0; m_n = 0;
    end else begin
      m_n++;
      m_jump = 0;
      if (upd) begin
        if (m_st == 0) begin
          if (start) m_st = 1;
        end else if (m_st == 1) begin
          if (left && !right) m_x = (m_x < STEP) ? m_x + W - STEP : m_x - STEP;
          else if (right && !left) begin
            m_x += STEP;
            if (m_x >= W) m_x -= W;
          end
          if (on_platform && m_v <= 0) begin
            m_v = JV; m_jump = 1; m_scroll = 0;
          end else begin
            ny = m_y - m_v;
            nv = (m_v - 1 < -MF) ? -MF : m_v - 1;
            if (ny < TOP) begin
              m_y = TOP; m_scroll = TOP - ny; m_v = nv;
            end else if (ny >= H) begin
              m_st = 2; m_scroll = 0;
            end else begin
              m_y = ny; m_v = nv; m_scroll = 0;
            end
          end
        end
      end
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic l, input logic rt, input logic p);
    reset = r; start = s; left = l; right = rt; on_platform = p;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("frame_tick", int'(ft), tick_exp(m_n, 1));
      check("pos_x", int'(px), m_x);
      check("pos_y", int'(py), m_y);
      check("vel_y", int'(vy), m_v);
      check("jump", int'(jmp), m_jump);
      check("scroll_amt", int'(scr), m_scroll);
      check("game_over", int'(go), (m_st == 2) ? 1 : 0);
      check("div_frame_tick", int'(d_ft), tick_exp(m_n, 4));
      check("div_pos_x", int'(d_px), 200);
      check("div_pos_y", int'(d_py), 600);
      check("div_vel_y", int'(d_vy), 0);
      check("div_jump", int'(d_jmp), 0);
      check("div_scroll", int'(d_scr), 0);
      check("div_game_over", int'(d_go), 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sy;
    // Reset values and first ticks after start.
    cyc(1, 0, 0, 0, 0);
    chk_en = 1'b1;
    check("rst_pos_x", int'(px), 198);
    check("rst_pos_y", int'(py), 600);
    check("rst_vel_y", int'(vy), 0);
    check("rst_tick", int'(ft), 0);
    check("rst_game_over", int'(go), 0);
    check("rst_div_pos_x", int'(d_px), 200);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("fall1_y", int'(py), 600); check("fall1_v", int'(vy), -1);
    check("div_tick_n3", int'(d_ft), 0);
    cyc(0, 0, 0, 0, 0);
    check("fall2_y", int'(py), 601); check("fall2_v", int'(vy), -2);
    check("div_tick_n4", int'(d_ft), 1);
    cyc(0, 0, 0, 0, 0);
    check("fall3_y", int'(py), 603); check("fall3_v", int'(vy), -3);
    cyc(0, 0, 0, 0, 1);
    check("bounce_v", int'(vy), 16); check("bounce_jump", int'(jmp), 1);
    check("bounce_y", int'(py), 603);
    cyc(0, 0, 0, 0, 0);
    check("rise_y", int'(py), 587); check("rise_v", int'(vy), 15);
    check("jump_clear", int'(jmp), 0);
    for (int k = 0; k < 40 && m_v != 5; k++) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    check("rising_plat_v", int'(vy), 4); check("rising_plat_jump", int'(jmp), 0);
    check("rising_plat_y", int'(py), 477);

    // Trajectory to apex 205, then the top clamp.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    check("b600_v", int'(vy), 16); check("b600_y", int'(py), 600);
    for (int k = 0; k < 40 && m_v != 0; k++) cyc(0, 0, 0, 0, 0);
    check("apex464_y", int'(py), 464);
    for (int k = 0; k < 10 && m_y != 467; k++) cyc(0, 0, 0, 0, 0);
    check("pre467_v", int'(vy), -3);
    cyc(0, 0, 0, 0, 1);
    for (int k = 0; k < 40 && m_v != 0; k++) cyc(0, 0, 0, 0, 0);
    check("apex331_y", int'(py), 331);
    for (int k = 0; k < 10 && m_y != 341; k++) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    for (int k = 0; k < 40 && m_v != 0; k++) cyc(0, 0, 0, 0, 0);
    check("apex205_y", int'(py), 205);
    cyc(0, 0, 0, 0, 1);
    check("b205_v", int'(vy), 16); check("b205_jump", int'(jmp), 1);
    cyc(0, 0, 0, 0, 0);
    check("clamp1_y", int'(py), 200); check("clamp1_scroll", int'(scr), 11);
    check("clamp1_v", int'(vy), 15);
    cyc(0, 0, 0, 0, 0);
    check("clamp2_y", int'(py), 200); check("clamp2_scroll", int'(scr), 15);

    // Horizontal wrap while bouncing to stay alive.
    for (int k = 0; k < 120 && m_x != 398; k++) cyc(0, 0, 0, 1, m_v <= 0);
    check("x_398", int'(px), 398);
    cyc(0, 0, 0, 1, m_v <= 0);
    check("wrap_right", int'(px), 2);
    cyc(0, 0, 1, 0, m_v <= 0);
    check("wrap_left", int'(px), 398);
    cyc(0, 0, 1, 1, m_v <= 0);
    check("both_hold", int'(px), 398);

    // Fall to death, stay frozen, reset out.
    for (int k = 0; k < 300 && m_st != 2; k++)
      cyc(0, 1'($urandom), 1'($urandom), 1'($urandom), 0);
    check("dead_game_over", int'(go), 1);
    check("dead_vel_sat", int'(vy), -16);
    sy = m_y;
    for (int k = 0; k < 10; k++)
      cyc(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    check("dead_frozen_y", int'(py), sy);
    check("dead_still", int'(go), 1);
    cyc(1, 0, 0, 0, 0);
    check("dead_rst_x", int'(px), 198); check("dead_rst_y", int'(py), 600);
    check("dead_rst_go", int'(go), 0);

    // Random play with occasional resets.
    for (int k = 0; k < 3000; k++)
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
          1'($urandom), 1'($urandom), $urandom_range(0, 2) == 0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/doodle_motion.md
Name: doodle_motion

Overview:
Player physics engine for the Doodle Jump game. Generates its own frame tick from clk and, on each tick, updates the player position:
- horizontal movement from left/right, wrapping around the screen edges;
- vertical velocity under gravity, with a bounce when landing on a platform;
- a top-of-screen clamp that produces a world-scroll amount.
Sits inside GameBox between the input buttons, the platform collision checker and the renderer.

Parameters:
SCR_W, 400, screen width in pixels
SCR_H, 700, screen height in pixels; y grows downward
X_W, 10, pos_x width
Y_W, 10, pos_y width
V_W, 8, signed vel_y width
TICK_DIV, 1, clk cycles per frame tick (≥1)
GRAVITY, 1, vel_y decrement per tick
JUMP_V, 16, vel_y loaded on bounce (positive = upward)
MAX_FALL, 16, magnitude clamp for negative vel_y
MOVE_STEP, 4, horizontal pixels per tick
TOP_LIMIT, 200, minimum pos_y; excess becomes scroll
START_X, 200, reset x
START_Y, 600, reset y

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  leave IDLE
left  in  1  move-left button
right  in  1  move-right button
on_platform  in  1  collision checker: feet on a platform top this frame
frame_tick  out  1  one-cycle pulse, frame update strobe
pos_x  out  X_W  player x
pos_y  out  Y_W  player y (feet)
vel_y  out  V_W  signed vertical velocity
jump  out  1  one-cycle pulse on bounce
scroll_amt  out  Y_W  pixels the world scrolls down this frame
game_over  out  1  high in DEAD

Behaviour:
- Reset (synchronous, wins over everything, effective at any time including mid-game). Outputs and state take these values at the next edge: pos_x=START_X, pos_y=START_Y, vel_y=0, jump=0, scroll_amt=0, frame_tick=0, game_over=0, tick counter=0, state=IDLE.
- Tick divider:
  - Counter runs 0..TICK_DIV-1.
  - frame_tick is registered, high for the one cycle after the counter reaches TICK_DIV-1.
  - TICK_DIV=1 gives frame_tick high every cycle after reset.
  - All updates below happen on an edge where frame_tick=1, using inputs sampled at that edge.
  - jump and scroll_amt are valid in the following cycle; jump is 0 on non-update cycles, and scroll_amt holds its value until the next update.
- States:
  - IDLE: no motion; on an update edge, goes to PLAY if start=1.
  - PLAY: physics as below.
  - DEAD: everything frozen; game_over=1; leaves only via reset.
- Horizontal (PLAY):
  - left&~right: pos_x -= MOVE_STEP, wrapping: if pos_x < MOVE_STEP, pos_x = pos_x + SCR_W - MOVE_STEP.
  - right&~left: pos_x += MOVE_STEP, wrapping: if result ≥ SCR_W, subtract SCR_W.
  - Both or neither: hold.
- Vertical (PLAY):
  - Bounce: on_platform=1 and vel_y ≤ 0 → vel_y=JUMP_V, pos_y unchanged, jump=1.
  - on_platform with vel_y > 0 (rising through a platform) is ignored.
  - Otherwise:
    - ny = pos_y - vel_y, using the old vel_y and computed signed at Y_W+2 bits.
    - vel_y = max(vel_y - GRAVITY, -MAX_FALL).
  - ny < TOP_LIMIT → pos_y=TOP_LIMIT, scroll_amt = TOP_LIMIT - ny.
  - ny ≥ SCR_H → state=DEAD, game_over=1, pos_y/vel_y hold their old values.
  - Otherwise pos_y=ny, scroll_amt=0.
- Horizontal and vertical updates apply on the same tick.
- No output changes on non-tick cycles except frame_tick and the jump clear.

Test Plan:
- TICK_DIV=4, reset, right=1, start=0 → frame_tick pulses every 4th cycle; pos_x=200, pos_y=600, vel_y=0, state IDLE throughout.
- TICK_DIV=1, start on tick 0, no platform → subsequent ticks give pos_y/vel_y 600/-1, 601/-2, 603/-3; vel_y saturates at -16, never -17.
- In PLAY with vel_y=-3, on_platform=1 → vel_y=16, jump pulses one cycle, pos_y unchanged; next tick pos_y decreases by 16, vel_y=15. Separately, on_platform with vel_y=5 → no bounce.
- Horizontal wrap:
  - pos_x=398, right → 2.
  - pos_x=2, left → 398.
  - left&right → pos_x unchanged.
- pos_y=205, vel_y=16 → pos_y=200, scroll_amt=11; next tick with vel_y=15 → pos_y=200, scroll_amt=15.
- pos_y=695, vel_y=-8 → game_over=1, pos frozen across 10 further ticks with any inputs; reset mid-DEAD → IDLE, START values next edge.
